// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers PC-tagged responses, flushes on redirect.
// Define PFQ_BYPASS_EN to forward a kept response straight to fetch when the FIFO is empty.
module instr_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     req_valid,
    output logic [31:0]              req_addr,
    input  logic                     req_ready,
    input  logic                     rsp_valid,
    input  logic [31:0]              rsp_data,
    output logic                     fe_valid,
    output logic [31:0]              fe_instr,
    output logic [31:0]              fe_pc,
    input  logic                     fe_ready,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam logic [AW:0]   MAX_O   = (AW+1)'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d, outst_q, outst_d, disc_q, disc_d;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];

    logic          empty, rsp_ok, rsp_keep, req_fire, pop, push, byp, byp_take;
    logic [AW:0]   rsp_one, req_one, push_one, pop_one;
    logic [CW-1:0] credit;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign empty    = (count_q == '0);
    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp_ok   = rsp_valid & (outst_q != '0);
    assign rsp_keep = rsp_ok & (disc_q == '0) & ~redirect_valid;

    // Credit counts every slot already promised to a kept response.
    assign credit    = CW'(count_q) + CW'(outst_q) - CW'(disc_q);
    assign req_valid = EN & ~redirect_valid & (outst_q < MAX_O) & (credit < DEPTH_C);
    assign req_addr  = fetch_pc_q;
    assign req_fire  = req_valid & req_ready;

`ifdef PFQ_BYPASS_EN
    assign byp = rsp_keep & empty;
`else
    assign byp = 1'b0;
`endif

    assign fe_valid  = ~empty | byp;
    assign byp_take  = byp & fe_ready & EN;
    assign pop       = ~empty & fe_ready & EN & ~redirect_valid;
    assign push      = rsp_keep & ~byp_take;
    assign occupancy = count_q;

    assign rsp_one  = {{AW{1'b0}}, rsp_ok};
    assign req_one  = {{AW{1'b0}}, req_fire};
    assign push_one = {{AW{1'b0}}, push};
    assign pop_one  = {{AW{1'b0}}, pop};

    always_comb begin
        fe_instr = '0;
        fe_pc    = '0;
        if (!empty) begin
            fe_instr = mem_instr_q[rd_ptr_q];
            fe_pc    = mem_pc_q[rd_ptr_q];
        end else if (byp) begin
            fe_instr = rsp_data;
            fe_pc    = rsp_pc_q;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        disc_d     = disc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            outst_d    = outst_q - rsp_one;
            disc_d     = outst_q - rsp_one;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
            if (rsp_ok && disc_q != '0) disc_d = disc_q - (AW+1)'(1);
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + push_one - pop_one;
            outst_d = outst_q + req_one - rsp_one;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            disc_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            disc_q     <= disc_d;
        end
    end

    // FIFO storage carries no reset; visibility is governed by count_q.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
            mem_instr_q[wr_ptr_q] <= rsp_data;
        end
    end

    assert property (@(posedge CLK) disable iff (RST) rsp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a queue-based reference model and a behavioural 1-cycle MMU.
module tb_instr_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
`ifdef PFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK, RST, EN, redirect_valid, req_valid, req_ready, rsp_valid, fe_valid, fe_ready;
    logic [31:0] redirect_pc, req_addr, rsp_data, fe_instr, fe_pc;
    logic [2:0]  occupancy;

    instr_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .fe_valid(fe_valid), .fe_instr(fe_instr), .fe_pc(fe_pc), .fe_ready(fe_ready),
        .occupancy(occupancy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_hs    = 0;
    bit chk_on  = 1'b0;
    bit mmu_auto;
    logic [31:0] mmu_q[$];

    // Reference model state
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [31:0] m_fetch, m_rsp;
    int          m_out, m_disc;
    bit          m_consumed;
    bit          e_req_valid, e_byp, e_fe_valid;
    logic [31:0] e_fe_instr, e_fe_pc;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        e_req_valid = EN && !redirect_valid && (m_out < MAXO) && (q_pc.size() + m_out - m_disc < DEPTH);
        e_byp       = BYP && (q_pc.size() == 0) && (m_disc == 0) && !redirect_valid && rsp_valid;
        e_fe_valid  = (q_pc.size() > 0) || e_byp;
        e_fe_instr  = 32'h0;
        e_fe_pc     = 32'h0;
        if (q_pc.size() > 0) begin
            e_fe_instr = q_in[0];
            e_fe_pc    = q_pc[0];
        end else if (e_byp) begin
            e_fe_instr = rsp_data;
            e_fe_pc    = m_rsp;
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Model update at each rising edge
    initial begin
        forever begin
            @(posedge CLK);
            if (RST) begin
                q_pc.delete(); q_in.delete();
                m_fetch = 32'h0; m_rsp = 32'h0; m_out = 0; m_disc = 0;
            end else begin
                model_eval();
                if (redirect_valid) begin
                    q_pc.delete(); q_in.delete();
                    m_fetch = {redirect_pc[31:2], 2'b00};
                    m_rsp   = {redirect_pc[31:2], 2'b00};
                    if (rsp_valid) m_out--;
                    m_disc = m_out;
                end else begin
                    m_consumed = 1'b0;
                    if (EN && fe_ready && e_fe_valid) begin
                        if (q_pc.size() > 0) begin
                            void'(q_pc.pop_front());
                            void'(q_in.pop_front());
                        end else m_consumed = 1'b1;
                    end
                    if (rsp_valid) begin
                        m_out--;
                        if (m_disc > 0) m_disc--;
                        else begin
                            if (!m_consumed) begin
                                q_pc.push_back(m_rsp);
                                q_in.push_back(rsp_data);
                            end
                            m_rsp = m_rsp + 32'd4;
                        end
                    end
                    if (e_req_valid && req_ready) begin
                        m_fetch = m_fetch + 32'd4;
                        m_out++;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_on) begin
                model_eval();
                check32("req_valid", 32'(req_valid), 32'(e_req_valid));
                check32("req_addr", req_addr, m_fetch);
                check32("fe_valid", 32'(fe_valid), 32'(e_fe_valid));
                check32("fe_instr", fe_instr, e_fe_instr);
                check32("fe_pc", fe_pc, e_fe_pc);
                check32("occupancy", 32'(occupancy), 32'(q_pc.size()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // One clock cycle including the behavioural MMU
    task automatic cyc();
        logic        hs;
        logic [31:0] a;
        @(negedge CLK);
        hs = req_valid & req_ready;
        a  = req_addr;
        @(posedge CLK);
        #1;
        if (hs) begin
            mmu_q.push_back(a);
            n_hs++;
        end
        if (mmu_auto && mmu_q.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mmu_q.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
    endtask

    task automatic peek();
        #1;
    endtask

    initial begin
        int nw;
        int h0;
        RST = 1'b1; EN = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0; fe_ready = 1'b0; mmu_auto = 1'b1;

        // Reset for two edges
        cyc();
        chk_on = 1'b1;
        cyc(); peek();
        check32("rst_req_valid", 32'(req_valid), 32'h0);
        check32("rst_fe_valid", 32'(fe_valid), 32'h0);
        check32("rst_fe_instr", fe_instr, 32'h0);
        check32("rst_fe_pc", fe_pc, 32'h0);
        check32("rst_occupancy", 32'(occupancy), 32'h0);

        // Boot stream from address 0
        RST = 1'b0; EN = 1'b1; fe_ready = 1'b1;
        peek();
        check32("boot_req_valid", 32'(req_valid), 32'h1);
        check32("boot_req_addr", req_addr, 32'h0);
        nw = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(); peek();
            if (fe_valid) begin
                check32("boot_pc", fe_pc, 32'(4 * nw));
                if (nw == 0) check32("boot_instr0", fe_instr, 32'hBEEF_0000);
                if (nw == 1) check32("boot_instr1", fe_instr, 32'hBEEB_0004);
                nw++;
            end
        end
        check32("boot_throughput", 32'(nw >= 7), 32'h1);

        // Backpressure fills the FIFO; one pop admits one request
        fe_ready = 1'b0;
        repeat (10) cyc();
        peek();
        check32("bp_occupancy", 32'(occupancy), 32'd4);
        check32("bp_req_valid", 32'(req_valid), 32'h0);
        h0 = n_hs;
        fe_ready = 1'b1;
        cyc();
        fe_ready = 1'b0;
        repeat (6) cyc();
        peek();
        check32("bp_one_request", 32'(n_hs - h0), 32'd1);
        check32("bp_refill", 32'(occupancy), 32'd4);

        // Redirect together with a response and a pop
        mmu_auto = 1'b0; fe_ready = 1'b1;
        cyc();
        cyc();
        fe_ready = 1'b0; mmu_auto = 1'b1;
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h100; fe_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        peek();
        check32("rdr_occupancy", 32'(occupancy), 32'h0);
        check32("rdr_fe_valid", 32'(fe_valid), 32'h0);
        check32("rdr_req_valid", 32'(req_valid), 32'h1);
        check32("rdr_req_addr", req_addr, 32'h100);
        repeat (6) cyc();

        // Flush with two requests in flight
        mmu_auto = 1'b0;
        repeat (6) cyc();
        peek();
        check32("flush_pre_req_valid", 32'(req_valid), 32'h0);
        check32("flush_pre_empty", 32'(occupancy), 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc();
        redirect_valid = 1'b0; mmu_auto = 1'b1;
        nw = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(); peek();
            if (fe_valid) begin
                check32("flush_pc", fe_pc, 32'h100 + 32'(4 * nw));
                if (nw == 0) check32("flush_instr0", fe_instr, 32'hBFEF_0100);
                nw++;
            end
        end
        check32("flush_progress", 32'(nw >= 4), 32'h1);

        // Unaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        cyc();
        redirect_valid = 1'b0;
        peek();
        check32("unal_req_addr", req_addr, 32'h200);
        nw = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(); peek();
            if (fe_valid) begin
                check32("unal_pc", fe_pc, 32'h200 + 32'(4 * nw));
                if (nw == 0) check32("unal_instr0", fe_instr, 32'hBCEF_0200);
                nw++;
            end
        end

        // EN low while two responses are in flight
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        cyc();
        redirect_valid = 1'b0; mmu_auto = 1'b0;
        repeat (3) cyc();
        peek();
        check32("en0_pre_req_valid", 32'(req_valid), 32'h0);
        check32("en0_pre_fe_valid", 32'(fe_valid), 32'h0);
        EN = 1'b0; mmu_auto = 1'b1; h0 = n_hs;
        cyc(); peek();
        check32("en0_first_fe_valid", 32'(fe_valid), 32'(BYP));
        check32("en0_first_occ", 32'(occupancy), 32'h0);
        if (BYP) check32("en0_byp_pc", fe_pc, 32'h400);
        cyc(); peek();
        check32("en0_occ1", 32'(occupancy), 32'd1);
        check32("en0_fe_valid", 32'(fe_valid), 32'h1);
        check32("en0_fe_pc", fe_pc, 32'h400);
        check32("en0_fe_instr", fe_instr, 32'hBAEF_0400);
        cyc(); peek();
        check32("en0_occ2", 32'(occupancy), 32'd2);
        check32("en0_req_valid", 32'(req_valid), 32'h0);
        repeat (3) cyc();
        peek();
        check32("en0_hold_occ", 32'(occupancy), 32'd2);
        check32("en0_hold_pc", fe_pc, 32'h400);
        check32("en0_no_request", 32'(n_hs - h0), 32'h0);
        EN = 1'b1;
        repeat (8) cyc();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
